// File: rtl/hood_mode_fsm_pkg.sv
// Shared hood definitions: front-panel mode codes, controller state set and
// small helpers used by the mode FSM, the display and the timer blocks.
package hood_mode_fsm_pkg;

  // Codes shown on mode_state; the display decodes exactly these values.
  localparam logic [2:0] MODE_OFF   = 3'b000;
  localparam logic [2:0] MODE_L1    = 3'b001;
  localparam logic [2:0] MODE_L2    = 3'b010;
  localparam logic [2:0] MODE_L3    = 3'b011;
  localparam logic [2:0] MODE_CLEAN = 3'b100;

  // Controller states. DRAIN runs the fan at level 2 after a cut-short level 3.
  typedef enum logic [2:0] {
    ST_OFF,
    ST_STANDBY,
    ST_L1,
    ST_L2,
    ST_L3,
    ST_DRAIN,
    ST_CLEAN
  } hood_state_e;

  // Panel code for a controller state; standby shows the same code as off.
  function automatic logic [2:0] mode_of(hood_state_e s);
    logic [2:0] m;
    case (s)
      ST_L1:             m = MODE_L1;
      ST_L2, ST_DRAIN:   m = MODE_L2;
      ST_L3:             m = MODE_L3;
      ST_CLEAN:          m = MODE_CLEAN;
      default:           m = MODE_OFF;
    endcase
    return m;
  endfunction

  // States that run against the seconds countdown.
  function automatic logic is_timed(hood_state_e s);
    return (s == ST_L3) || (s == ST_DRAIN) || (s == ST_CLEAN);
  endfunction

endpackage

// File: rtl/hood_mode_fsm_sec_tick_gen.sv
// One-second tick generator: counts 0..TICKS_PER_SEC-1 and flags the last
// count. clr holds the count at 0 so every timed state starts a fresh second.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap after the last cycle of a second, or hold at 0 on clr.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/hood_mode_fsm.sv
// Cooker-hood mode controller: power/standby handling, menu-armed mode
// selection, level 3 with its once-per-session lockout, post-level-3 drain
// and timed self-clean. All outputs come straight from flops.
module hood_mode_fsm
  import hood_mode_fsm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MODE3_SECS    = 60,
  parameter int CLEAN_SECS    = 180,
  parameter int DRAIN_SECS    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        machine_on,
  input  logic        menu_pulse,
  input  logic        mode1_pulse,
  input  logic        mode2_pulse,
  input  logic        mode3_pulse,
  input  logic        clean_pulse,
  output logic [2:0]  mode_state,
  output logic [7:0]  countdown_sec,
  output logic        menu_armed,
  output logic        mode3_used,
  output logic        clean_done,
  output hood_state_e state_dbg
);

  // The countdown is 8 bits wide and must start at least at 1 second.
  if ((MODE3_SECS < 1) || (MODE3_SECS > 255)) begin : g_bad_mode3_secs
    $error("hood_mode_fsm: MODE3_SECS must be in 1..255");
  end
  if ((CLEAN_SECS < 1) || (CLEAN_SECS > 255)) begin : g_bad_clean_secs
    $error("hood_mode_fsm: CLEAN_SECS must be in 1..255");
  end
  if ((DRAIN_SECS < 1) || (DRAIN_SECS > 255)) begin : g_bad_drain_secs
    $error("hood_mode_fsm: DRAIN_SECS must be in 1..255");
  end

  localparam logic [7:0] MODE3_N = 8'(MODE3_SECS);
  localparam logic [7:0] CLEAN_N = 8'(CLEAN_SECS);
  localparam logic [7:0] DRAIN_N = 8'(DRAIN_SECS);

  hood_state_e state_q, state_d;
  logic [2:0]  mode_q;
  logic [7:0]  cd_q, cd_d;
  logic        armed_q, armed_d;
  logic        used_q, used_d;
  logic        done_q, done_d;
  logic        tick;
  logic        tick_clr;
  logic        expired;

  // The timed state ends on the tick that would take the countdown to 0.
  assign expired = tick && (cd_q == 8'd1);

  // Restart the second whenever the state changes, and park it outside
  // the timed states, so each dwell is exactly N whole seconds.
  assign tick_clr = (state_d != state_q) || !is_timed(state_d);

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Next state and next output values. Power loss wins over every pulse;
  // among pulses the order is menu > mode3 > mode2 > mode1 > clean, and a
  // locked-out mode3 counts as no pulse at all.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    used_d  = used_q;
    cd_d    = cd_q;
    done_d  = 1'b0;
    if (!machine_on) begin
      state_d = ST_OFF;
      armed_d = 1'b0;
      used_d  = 1'b0;
      cd_d    = 8'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_STANDBY;
        end
        ST_STANDBY: begin
          if (!armed_q) begin
            if (menu_pulse) armed_d = 1'b1;
          end else if (menu_pulse) begin
            armed_d = 1'b0;
          end else if (mode3_pulse && !used_q) begin
            state_d = ST_L3;
            cd_d    = MODE3_N;
            used_d  = 1'b1;
            armed_d = 1'b0;
          end else if (mode2_pulse) begin
            state_d = ST_L2;
            armed_d = 1'b0;
          end else if (mode1_pulse) begin
            state_d = ST_L1;
            armed_d = 1'b0;
          end else if (clean_pulse) begin
            state_d = ST_CLEAN;
            cd_d    = CLEAN_N;
            armed_d = 1'b0;
          end
        end
        ST_L1, ST_L2: begin
          if (menu_pulse)       state_d = ST_STANDBY;
          else if (mode2_pulse) state_d = ST_L2;
          else if (mode1_pulse) state_d = ST_L1;
        end
        ST_L3: begin
          // Expiry beats a menu press arriving on the same edge.
          if (expired) begin
            state_d = ST_STANDBY;
            cd_d    = 8'd0;
          end else if (menu_pulse) begin
            state_d = ST_DRAIN;
            cd_d    = DRAIN_N;
          end else if (tick) begin
            cd_d = cd_q - 8'd1;
          end
        end
        ST_DRAIN, ST_CLEAN: begin
          if (expired) begin
            state_d = ST_STANDBY;
            cd_d    = 8'd0;
            done_d  = (state_q == ST_CLEAN);
          end else if (tick) begin
            cd_d = cd_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_OFF;
          armed_d = 1'b0;
          used_d  = 1'b0;
          cd_d    = 8'd0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      mode_q  <= MODE_OFF;
      cd_q    <= 8'd0;
      armed_q <= 1'b0;
      used_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_of(state_d);
      cd_q    <= cd_d;
      armed_q <= armed_d;
      used_q  <= used_d;
      done_q  <= done_d;
    end
  end

  assign mode_state    = mode_q;
  assign countdown_sec = cd_q;
  assign menu_armed    = armed_q;
  assign mode3_used    = used_q;
  assign clean_done    = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Bench for hood_mode_fsm: a vector table, multi-cycle corner sequences and
// random traffic, all checked every cycle against a cycle-budget model.
module tb_hood_mode_fsm;
  import hood_mode_fsm_pkg::*;

  localparam int T  = 10;
  localparam int M3 = 3;
  localparam int CL = 5;
  localparam int DR = 2;

  // Pulse vector layout: {menu, mode3, mode2, mode1, clean}
  localparam logic [4:0] PL_NONE = 5'b00000;
  localparam logic [4:0] PL_MENU = 5'b10000;
  localparam logic [4:0] PL_M3   = 5'b01000;
  localparam logic [4:0] PL_M2   = 5'b00100;
  localparam logic [4:0] PL_M1   = 5'b00010;
  localparam logic [4:0] PL_CLN  = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic machine_on = 1'b0;
  logic menu_pulse = 1'b0, mode1_pulse = 1'b0, mode2_pulse = 1'b0;
  logic mode3_pulse = 1'b0, clean_pulse = 1'b0;
  logic [2:0]  mode_state;
  logic [7:0]  countdown_sec;
  logic        menu_armed, mode3_used, clean_done;
  hood_state_e state_dbg;

  always #5 clk = ~clk;

  hood_mode_fsm #(
    .TICKS_PER_SEC (T),
    .MODE3_SECS    (M3),
    .CLEAN_SECS    (CL),
    .DRAIN_SECS    (DR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .machine_on    (machine_on),
    .menu_pulse    (menu_pulse),
    .mode1_pulse   (mode1_pulse),
    .mode2_pulse   (mode2_pulse),
    .mode3_pulse   (mode3_pulse),
    .clean_pulse   (clean_pulse),
    .mode_state    (mode_state),
    .countdown_sec (countdown_sec),
    .menu_armed    (menu_armed),
    .mode3_used    (mode3_used),
    .clean_done    (clean_done),
    .state_dbg     (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Timed states are tracked as a budget of remaining clock cycles; the
  // displayed seconds are that budget rounded up to whole seconds.
  typedef enum int {PH_OFF, PH_STBY, PH_L1, PH_L2, PH_L3, PH_DRAIN, PH_CLEAN} phase_e;
  phase_e m_phase = PH_OFF;
  bit     m_armed = 1'b0;
  bit     m_used  = 1'b0;
  bit     m_done  = 1'b0;
  int     m_left  = 0;

  function automatic logic [13:0] model_out();
    logic [2:0] md;
    logic [7:0] cd;
    case (m_phase)
      PH_L1:              md = 3'd1;
      PH_L2, PH_DRAIN:    md = 3'd2;
      PH_L3:              md = 3'd3;
      PH_CLEAN:           md = 3'd4;
      default:            md = 3'd0;
    endcase
    if (m_phase == PH_L3 || m_phase == PH_DRAIN || m_phase == PH_CLEAN)
      cd = 8'((m_left + T - 1) / T);
    else
      cd = 8'd0;
    return {md, cd, m_armed, m_used, m_done};
  endfunction

  function automatic void model_step(bit rst, bit on, logic [4:0] p);
    bit menu, m3, m2, m1, cln;
    {menu, m3, m2, m1, cln} = p;
    m_done = 1'b0;
    if (rst || !on) begin
      m_phase = PH_OFF; m_armed = 1'b0; m_used = 1'b0; m_left = 0;
      return;
    end
    case (m_phase)
      PH_OFF: m_phase = PH_STBY;
      PH_STBY: begin
        if (!m_armed) begin
          if (menu) m_armed = 1'b1;
        end else if (menu) m_armed = 1'b0;
        else if (m3 && !m_used) begin
          m_phase = PH_L3; m_left = M3 * T; m_used = 1'b1; m_armed = 1'b0;
        end else if (m2) begin m_phase = PH_L2; m_armed = 1'b0; end
        else if (m1) begin m_phase = PH_L1; m_armed = 1'b0; end
        else if (cln) begin m_phase = PH_CLEAN; m_left = CL * T; m_armed = 1'b0; end
      end
      PH_L1, PH_L2: begin
        if (menu)    m_phase = PH_STBY;
        else if (m2) m_phase = PH_L2;
        else if (m1) m_phase = PH_L1;
      end
      PH_L3: begin
        if (m_left == 1) begin m_phase = PH_STBY; m_left = 0; end
        else if (menu) begin m_phase = PH_DRAIN; m_left = DR * T; end
        else m_left--;
      end
      default: begin
        if (m_left == 1) begin
          m_done  = (m_phase == PH_CLEAN);
          m_phase = PH_STBY; m_left = 0;
        end else m_left--;
      end
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive inputs, let the edge happen, compare every output
  // with the model just after the edge.
  task automatic apply(input bit rst, input bit on, input logic [4:0] p);
    logic [13:0] got;
    logic [13:0] want;
    reset = rst;
    machine_on = on;
    {menu_pulse, mode3_pulse, mode2_pulse, mode1_pulse, clean_pulse} = p;
    @(posedge clk);
    model_step(rst, on, p);
    exp_q.push_back(model_out());
    #1;
    got  = {mode_state, countdown_sec, menu_armed, mode3_used, clean_done};
    want = exp_q.pop_front();
    check("model", 32'(got), 32'(want));
    {menu_pulse, mode3_pulse, mode2_pulse, mode1_pulse, clean_pulse} = 5'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b1, PL_NONE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    bit         on;
    logic [4:0] p;
    logic [2:0] mode;
    logic [7:0] cd;
    bit         armed;
    bit         used;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit on, logic [4:0] p, logic [2:0] md,
                              logic [7:0] cd, bit a, bit u, string nm);
    vec_t v;
    v.rst = rst; v.on = on; v.p = p; v.mode = md; v.cd = cd;
    v.armed = a; v.used = u; v.name = nm;
    return v;
  endfunction

  int cnt;
  int dones;

  initial begin
    vecs.push_back(mk(1, 0, PL_NONE,              3'd0, 8'd0, 0, 0, "reset"));
    vecs.push_back(mk(0, 1, PL_NONE,              3'd0, 8'd0, 0, 0, "power_on_standby"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 1, 0, "menu_arms"));
    vecs.push_back(mk(0, 1, PL_M2,                3'd2, 8'd0, 0, 0, "select_l2"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 0, 0, "l2_menu_standby"));
    vecs.push_back(mk(0, 1, PL_M1,                3'd0, 8'd0, 0, 0, "unarmed_mode1_ignored"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 1, 0, "rearm"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 0, 0, "menu_disarms"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 1, 0, "arm_again"));
    vecs.push_back(mk(0, 1, PL_M1,                3'd1, 8'd0, 0, 0, "select_l1"));
    vecs.push_back(mk(0, 1, PL_M2,                3'd2, 8'd0, 0, 0, "l1_to_l2"));
    vecs.push_back(mk(0, 1, PL_MENU | PL_M1,      3'd0, 8'd0, 0, 0, "menu_beats_mode1"));
    vecs.push_back(mk(0, 1, PL_CLN,               3'd0, 8'd0, 0, 0, "unarmed_clean_ignored"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 1, 0, "arm_for_l3"));
    vecs.push_back(mk(0, 1, PL_M3 | PL_M2 | PL_CLN, 3'd3, 8'd3, 0, 1, "mode3_priority"));
    vecs.push_back(mk(0, 1, PL_M1,                3'd3, 8'd3, 0, 1, "l3_ignores_mode1"));
    vecs.push_back(mk(0, 0, PL_MENU,              3'd0, 8'd0, 0, 0, "power_off_in_l3"));
    vecs.push_back(mk(0, 1, PL_NONE,              3'd0, 8'd0, 0, 0, "power_back_on"));
    vecs.push_back(mk(0, 1, PL_MENU,              3'd0, 8'd0, 1, 0, "arm_l3_again"));
    vecs.push_back(mk(0, 1, PL_M3,                3'd3, 8'd3, 0, 1, "l3_unlocked_after_off"));
    vecs.push_back(mk(1, 1, PL_MENU,              3'd0, 8'd0, 0, 0, "reset_mid_l3"));
    vecs.push_back(mk(0, 1, PL_NONE,              3'd0, 8'd0, 0, 0, "after_reset_standby"));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].on, vecs[i].p);
      check(vecs[i].name, 32'({mode_state, countdown_sec, menu_armed, mode3_used}),
            32'({vecs[i].mode, vecs[i].cd, vecs[i].armed, vecs[i].used}));
    end

    // Level 3 full run: 30 cycles showing 011, then standby, lockout kept.
    apply(1'b0, 1'b1, PL_MENU);
    apply(1'b0, 1'b1, PL_M3);
    check("l3_entry_cd", 32'(countdown_sec), 32'd3);
    cnt = 1;
    while (mode_state == 3'd3 && cnt < 100) begin
      apply(1'b0, 1'b1, PL_NONE);
      if (cnt == 10) check("l3_cd_after_1s", 32'(countdown_sec), 32'd2);
      if (mode_state == 3'd3) cnt++;
    end
    check("l3_dwell_cycles", 32'(cnt), 32'(M3 * T));
    check("l3_exit_mode", 32'(mode_state), 32'd0);
    check("l3_used_kept", 32'(mode3_used), 32'd1);
    apply(1'b0, 1'b1, PL_MENU);
    apply(1'b0, 1'b1, PL_M3);
    check("l3_lockout", 32'(mode_state), 32'd0);
    apply(1'b0, 1'b1, PL_MENU);

    // Drain: fresh session, cut level 3 short, pulses during drain ignored.
    apply(1'b0, 1'b0, PL_NONE);
    apply(1'b0, 1'b1, PL_NONE);
    apply(1'b0, 1'b1, PL_MENU);
    apply(1'b0, 1'b1, PL_M3);
    idle(4);
    apply(1'b0, 1'b1, PL_MENU);
    check("drain_mode", 32'(mode_state), 32'd2);
    check("drain_cd", 32'(countdown_sec), 32'd2);
    cnt = 1;
    while (mode_state == 3'd2 && cnt < 100) begin
      apply(1'b0, 1'b1, 5'($urandom_range(0, 31)));
      if (mode_state == 3'd2) cnt++;
    end
    check("drain_dwell_cycles", 32'(cnt), 32'(DR * T));
    check("drain_exit_armed", 32'({mode_state, menu_armed}), 32'd0);

    // Self-clean: 50 cycles, one-cycle clean_done on the way out.
    apply(1'b0, 1'b1, PL_MENU);
    apply(1'b0, 1'b1, PL_CLN);
    check("clean_entry", 32'({mode_state, countdown_sec}), 32'({3'd4, 8'd5}));
    cnt = 1;
    dones = 0;
    while (mode_state == 3'd4 && cnt < 200) begin
      apply(1'b0, 1'b1, PL_NONE);
      if (mode_state == 3'd4) begin
        cnt++;
        dones += int'(clean_done);
      end
    end
    check("clean_dwell_cycles", 32'(cnt), 32'(CL * T));
    check("clean_done_early", 32'(dones), 32'd0);
    check("clean_done_pulse", 32'({mode_state, clean_done}), 32'({3'd0, 1'b1}));
    apply(1'b0, 1'b1, PL_NONE);
    check("clean_done_one_cycle", 32'(clean_done), 32'd0);

    // Power drop mid-clean.
    apply(1'b0, 1'b1, PL_MENU);
    apply(1'b0, 1'b1, PL_CLN);
    idle(7);
    apply(1'b0, 1'b0, PL_MENU);
    check("off_mid_clean", 32'({mode_state, countdown_sec, menu_armed, mode3_used, clean_done}), 32'd0);
    apply(1'b0, 1'b1, PL_NONE);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] p;
      for (int b = 0; b < 5; b++) p[b] = ($urandom_range(0, 9) == 0);
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 79) != 0, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hood_mode_fsm.md
HOOD_MODE_FSM -- requirements
Module: hood_mode_fsm

Interface
REQ-001 The block SHALL have exactly one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 Parameter TICKS_PER_SEC SHALL default to 100_000_000 and SHALL set the number of clk cycles per one-second tick.
REQ-003 Parameter MODE3_SECS SHALL default to 60 and SHALL set the level-3 run time in seconds.
REQ-004 Parameter CLEAN_SECS SHALL default to 180 and SHALL set the self-clean run time in seconds.
REQ-005 Parameter DRAIN_SECS SHALL default to 60 and SHALL set the post-level-3 drain time in seconds.
REQ-006 Port clk SHALL be an input, 1 bit wide, and SHALL be the system clock.
REQ-007 Port reset SHALL be an input, 1 bit wide, and SHALL be the synchronous active-high reset.
REQ-008 Port machine_on SHALL be an input, 1 bit wide, driven as a level by the on/off controller.
REQ-009 Ports menu_pulse, mode1_pulse, mode2_pulse, mode3_pulse and clean_pulse SHALL be inputs, 1 bit wide each, carrying debounced single-cycle pulses.
REQ-010 Port mode_state SHALL be an output, 3 bits wide: 000 standby/off, 001 level 1, 010 level 2, 011 level 3, 100 self-clean.
REQ-011 Port countdown_sec SHALL be an output, 8 bits wide, giving the remaining seconds of the active timed state and 0 otherwise.
REQ-012 Port menu_armed SHALL be an output, 1 bit wide, high while standby is waiting for a mode selection.
REQ-013 Port mode3_used SHALL be an output, 1 bit wide, high once level 3 has run in the current power-on session.
REQ-014 Port clean_done SHALL be an output, 1 bit wide, pulsing for 1 cycle when self-clean completes.

Function
REQ-015 The FSM SHALL have the states OFF, STANDBY, L1, L2, L3, DRAIN and CLEAN; in DRAIN, mode_state SHALL be 010.
REQ-016 In any state, machine_on=0 SHALL force OFF on the next edge and clear menu_armed, mode3_used and countdown_sec; this SHALL take priority over all pulses.
REQ-017 The FSM SHALL go OFF->STANDBY on the first edge at which machine_on=1.
REQ-018 In STANDBY with menu_armed=0, menu_pulse SHALL set menu_armed, and mode/clean pulses SHALL be ignored.
REQ-019 In STANDBY with menu_armed=1, mode1->L1, mode2->L2, mode3->L3 (only if mode3_used=0, otherwise ignored) and clean->CLEAN; every accepted transition SHALL clear menu_armed, and menu_pulse SHALL clear menu_armed.
REQ-020 When several pulses arrive in the same cycle, priority SHALL be menu > mode3 > mode2 > mode1 > clean.
REQ-021 In L1/L2, mode1/mode2 SHALL switch directly between the levels, menu SHALL go to STANDBY, and mode3/clean SHALL be ignored.
REQ-022 Entry into L3 SHALL set mode3_used; at expiry L3 SHALL go to STANDBY, menu_pulse SHALL go to DRAIN, and other pulses SHALL be ignored.
REQ-023 DRAIN and CLEAN SHALL ignore all pulses and SHALL go to STANDBY at expiry; CLEAN expiry SHALL also assert clean_done.
REQ-024 On entry to L3, DRAIN or CLEAN, countdown_sec SHALL load N (the state's SECS value) in the entry cycle and the tick counter SHALL restart at 0.
REQ-025 countdown_sec SHALL decrement on each tick; the state SHALL exit on the edge at which the tick fires with countdown_sec=1, so the dwell is exactly N*TICKS_PER_SEC cycles.
REQ-026 The tick counter SHALL run 0..TICKS_PER_SEC-1 and wrap; it SHALL be held at 0 outside the timed states.
REQ-027 All outputs SHALL be registered, and a state change SHALL be visible one cycle after the causing input.
REQ-028 The SECS parameters SHALL be in the range 1..255; any other value SHALL be a configuration error.

Reset
REQ-029 reset=1 at a clk edge SHALL force OFF, mode_state=000, countdown_sec=0, menu_armed=0, mode3_used=0, clean_done=0 and tick counter=0, including when asserted mid-countdown.
REQ-030 After reset deasserts, the FSM SHALL follow REQ-017 on the next edge.

Structure
REQ-031 The mode_state encodings (000..100) SHALL live in a shared hood definitions package/header that the display and timer blocks also use.
REQ-032 The one-second tick generator SHALL be a sub-module sec_tick_gen with ports clk, reset, clr, tick and parameter TICKS_PER_SEC.

Verification
REQ-033 The bench SHALL use TICKS_PER_SEC=10, MODE3_SECS=3, CLEAN_SECS=5 and DRAIN_SECS=2.
REQ-034 Power-on select: machine_on=1, then menu, then mode2 -> mode_state=010 and menu_armed=0; then menu -> 000.
REQ-035 Level 3 expiry and lockout: menu, then mode3 -> 011 with countdown 3,2,1 and exit to 000 exactly 30 cycles later with mode3_used=1; then menu, then mode3 -> state stays 000.
REQ-036 Drain: in L3, menu -> mode_state=010, countdown=2, then 000 after 20 cycles; pulses during drain have no effect.
REQ-037 Clean: menu, then clean -> 100 for 50 cycles, clean_done high for 1 cycle, then 000.
REQ-038 Override: machine_on=0 mid-CLEAN -> OFF next cycle with all outputs 0; reset mid-L3 -> same; menu and mode1 in the same cycle from L2 -> STANDBY.
